// File: rtl/lane_shift_shim.sv
// Streaming shim: shifts each signed lane of an AXI-Stream beat left (saturating or
// wrapping) and buffers the result in a small FIFO with skid-free ready/valid handshakes.
module lane_shift_shim #(
    parameter int LANES    = 2,
    parameter int LANE_W   = 32,
    parameter int SHIFT    = 8,
    parameter int SATURATE = 1,
    parameter int DEPTH    = 4
) (
    input  logic                         s00_axis_aclk,
    input  logic                         s00_axis_areset,
    input  logic                         s00_axis_tvalid,
    input  logic                         s00_axis_tlast,
    input  logic [LANES*LANE_W-1:0]      s00_axis_tdata,
    input  logic [LANES*LANE_W/8-1:0]    s00_axis_tstrb,
    output logic                         s00_axis_tready,
    input  logic                         m00_axis_tready,
    output logic                         m00_axis_tvalid,
    output logic                         m00_axis_tlast,
    output logic [LANES*LANE_W-1:0]      m00_axis_tdata,
    output logic [LANES*LANE_W/8-1:0]    m00_axis_tstrb,
    input  logic                         bypass,
    output logic [$clog2(DEPTH):0]       occupancy,
    output logic [LANES-1:0]             sat_sticky,
    output logic [15:0]                  frame_count
);

    localparam int DW = LANES * LANE_W;
    localparam int SW = DW / 8;
    localparam int PW = $clog2(DEPTH);
    localparam int WW = LANE_W + SHIFT;

    localparam logic [PW:0]              FULL     = (PW + 1)'(DEPTH);
    localparam logic signed [LANE_W-1:0] LANE_MAX = {1'b0, {(LANE_W - 1){1'b1}}};
    localparam logic signed [LANE_W-1:0] LANE_MIN = {1'b1, {(LANE_W - 1){1'b0}}};

    // Returns {saturated, result}; the lane is widened first so overflow is visible
    // as a mismatch between the wide value and its sign-extended low half.
    function automatic logic [LANE_W:0] shift_lane(input logic [LANE_W-1:0] lane,
                                                   input logic              do_shift);
        logic signed [WW-1:0]     wide;
        logic signed [WW-1:0]     back;
        logic signed [LANE_W-1:0] low;
        wide = WW'(signed'(lane));
        if (do_shift) begin
            wide = wide <<< SHIFT;
        end
        low  = wide[LANE_W-1:0];
        back = WW'(low);
        if ((back != wide) && (SATURATE != 0)) begin
            return {1'b1, (wide[WW-1] ? LANE_MIN : LANE_MAX)};
        end
        return {1'b0, low};
    endfunction

    logic [DW-1:0]    mem_data [DEPTH];
    logic             mem_last [DEPTH];
    logic [SW-1:0]    mem_strb [DEPTH];

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             ready_en;
    logic             accept;
    logic             emit;
    logic [DW-1:0]    shifted;
    logic [LANES-1:0] sat_hit;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [LANE_W:0] res;
        assign res                          = shift_lane(s00_axis_tdata[g*LANE_W +: LANE_W], !bypass);
        assign shifted[g*LANE_W +: LANE_W]  = res[LANE_W-1:0];
        assign sat_hit[g]                   = res[LANE_W];
    end

    // ready_en holds tready low for the reset cycle itself without looking at the reset pin.
    assign s00_axis_tready = ready_en && (count != FULL);
    assign m00_axis_tvalid = (count != '0);
    assign accept          = s00_axis_tvalid && s00_axis_tready;
    assign emit            = m00_axis_tvalid && m00_axis_tready;

    assign m00_axis_tdata  = mem_data[rd_ptr];
    assign m00_axis_tlast  = mem_last[rd_ptr];
    assign m00_axis_tstrb  = mem_strb[rd_ptr];
    assign occupancy       = count;

    // NOTE: registered state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            ready_en    <= 1'b0;
            sat_sticky  <= '0;
            frame_count <= '0;
        end else begin
            ready_en <= 1'b1;
            if (accept) begin
                wr_ptr     <= wr_ptr + PW'(1);
                sat_sticky <= sat_sticky | sat_hit;
            end
            if (emit) begin
                rd_ptr <= rd_ptr + PW'(1);
                if (mem_last[rd_ptr]) begin
                    frame_count <= frame_count + 16'd1;
                end
            end
            case ({accept, emit})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only observed
    // once count says it was written, so its reset value would never be seen.
    always_ff @(posedge s00_axis_aclk) begin
        if (accept) begin
            mem_data[wr_ptr] <= shifted;
            mem_last[wr_ptr] <= s00_axis_tlast;
            mem_strb[wr_ptr] <= s00_axis_tstrb;
        end
    end

endmodule
